// File: rtl/control_unit.sv
// Multicycle main control FSM for the CPU datapath: fetch, decode, execute and exception entry
// for the supported MIPS subset. Strobes and selects are registered from the next state.
//
// state      | meaning
// FETCH1-2   | present PC to memory, ALU computes PC+4, wait for read data
// FETCH3     | capture IR, PC <= PC+4
// DECODE     | ALUout <= branch target, A/B load, dispatch on opcode/funct
// R_EXEC/WB  | register add/sub/and, overflow check, write rd
// ADDI_*     | immediate add, overflow check, write rt
// SH_*       | load shifter from B, shift by shamt, write rd
// JR / JUMP  | PC <= A / PC <= jump target
// BRANCH     | compare A-B, PC <= ALUout when the condition holds
// MEM_ADDR   | effective address into ALUout
// LW_*       | read data memory at ALUout, capture MDR, write rt
// SW_WRITE   | store B at ALUout
// EXC1-5     | EPC <= PC-4, fetch handler address from vector byte, PC <= vector
module control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OPCODE,
    input  logic [5:0] FUNCT,
    input  logic       Overflow,
    input  logic       Zero,
    output logic       PCwrite,
    output logic       MemWrite,
    output logic       MemRead,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       EPCWrite,
    output logic       MemToReg,
    output logic       RegDest,
    output logic       IorD,
    output logic [1:0] ExcpSel,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [2:0] ALUControl,
    output logic [2:0] ShiftControl,
    output logic [1:0] PCSource,
    output logic [1:0] WriteSrc,
    output logic [5:0] state_out
);

    typedef enum logic [5:0] {
        FETCH1    = 6'd0,
        FETCH2    = 6'd1,
        FETCH3    = 6'd2,
        DECODE    = 6'd3,
        R_EXEC    = 6'd4,
        R_WB      = 6'd5,
        ADDI_EXEC = 6'd6,
        ADDI_WB   = 6'd7,
        SH_LOAD   = 6'd8,
        SH_OP     = 6'd9,
        SH_WB     = 6'd10,
        JR        = 6'd11,
        JUMP      = 6'd12,
        BRANCH    = 6'd13,
        MEM_ADDR  = 6'd14,
        LW_READ   = 6'd15,
        LW_WAIT   = 6'd16,
        LW_LOAD   = 6'd17,
        LW_WB     = 6'd18,
        SW_WRITE  = 6'd19,
        EXC1      = 6'd20,
        EXC2      = 6'd21,
        EXC3      = 6'd22,
        EXC4      = 6'd23,
        EXC5      = 6'd24
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       mem_write;
        logic       mem_read;
        logic       ir_write;
        logic       reg_write;
        logic       epc_write;
        logic       reg_dest;
        logic       iord;
        logic [1:0] excp_sel;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [2:0] shift_control;
        logic [1:0] pc_source;
        logic [1:0] write_src;
    } ctrl_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2b;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_J    = 6'h02;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;

    localparam logic [2:0] SH_LOAD_B = 3'b001;
    localparam logic [2:0] SH_SLL    = 3'b010;
    localparam logic [2:0] SH_SRL    = 3'b011;

    localparam logic [1:0] VEC_ILLEGAL  = 2'd1;
    localparam logic [1:0] VEC_OVERFLOW = 2'd2;

    state_t     state;
    state_t     next_state;
    logic [1:0] exc_vec;
    logic [1:0] next_vec;
    ctrl_t      ctrl_q;
    ctrl_t      ctrl;
    logic       branch_take;

    function automatic logic [2:0] funct_alu(input logic [5:0] funct);
        case (funct)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] funct,
                                          input logic [1:0] vec);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH1, FETCH2: begin
                c.alu_src_b   = 2'd1;
                c.alu_control = ALU_ADD;
            end
            FETCH3: begin
                c.alu_src_b   = 2'd1;
                c.alu_control = ALU_ADD;
                c.ir_write    = 1'b1;
                c.pc_write    = 1'b1;
            end
            DECODE: begin
                c.alu_src_b   = 2'd3;
                c.alu_control = ALU_ADD;
            end
            R_EXEC: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = funct_alu(funct);
            end
            R_WB: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = funct_alu(funct);
                c.reg_dest    = 1'b1;
                c.reg_write   = 1'b1;
            end
            ADDI_EXEC, MEM_ADDR: begin
                c.alu_src_a   = 1'b1;
                c.alu_src_b   = 2'd2;
                c.alu_control = ALU_ADD;
            end
            ADDI_WB: c.reg_write = 1'b1;
            SH_LOAD: c.shift_control = SH_LOAD_B;
            SH_OP:   c.shift_control = (funct == FN_SLL) ? SH_SLL : SH_SRL;
            SH_WB: begin
                c.write_src = 2'd2;
                c.reg_dest  = 1'b1;
                c.reg_write = 1'b1;
            end
            JR: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = ALU_PASS;
                c.pc_write    = 1'b1;
            end
            JUMP: begin
                c.pc_source = 2'd2;
                c.pc_write  = 1'b1;
            end
            // pc_write for branches comes from Zero in the current cycle, see branch_take
            BRANCH: begin
                c.alu_src_a   = 1'b1;
                c.alu_control = ALU_SUB;
                c.pc_source   = 2'd1;
            end
            LW_READ, LW_WAIT: c.iord = 1'b1;
            LW_LOAD: begin
                c.iord     = 1'b1;
                c.mem_read = 1'b1;
            end
            LW_WB: begin
                c.write_src = 2'd1;
                c.reg_write = 1'b1;
            end
            SW_WRITE: begin
                c.iord      = 1'b1;
                c.mem_write = 1'b1;
            end
            EXC1: begin
                c.alu_src_b   = 2'd1;
                c.alu_control = ALU_SUB;
            end
            EXC2: begin
                c.epc_write = 1'b1;
                c.iord      = 1'b1;
                c.excp_sel  = vec;
            end
            EXC3: begin
                c.iord     = 1'b1;
                c.excp_sel = vec;
            end
            EXC4: begin
                c.iord     = 1'b1;
                c.excp_sel = vec;
                c.mem_read = 1'b1;
            end
            EXC5: begin
                c.pc_source = 2'd3;
                c.pc_write  = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        next_state = FETCH1;
        next_vec   = exc_vec;
        case (state)
            FETCH1: next_state = FETCH2;
            FETCH2: next_state = FETCH3;
            FETCH3: next_state = DECODE;
            DECODE: begin
                next_state = EXC1;
                next_vec   = VEC_ILLEGAL;
                case (OPCODE)
                    OP_R: begin
                        case (FUNCT)
                            FN_ADD, FN_SUB, FN_AND: next_state = R_EXEC;
                            FN_SLL, FN_SRL:         next_state = SH_LOAD;
                            FN_JR:                  next_state = JR;
                            default:                next_state = EXC1;
                        endcase
                    end
                    OP_ADDI:        next_state = ADDI_EXEC;
                    OP_LW, OP_SW:   next_state = MEM_ADDR;
                    OP_BEQ, OP_BNE: next_state = BRANCH;
                    OP_J:           next_state = JUMP;
                    default:        next_state = EXC1;
                endcase
            end
            // and never overflows architecturally, so only add/sub trap
            R_EXEC: begin
                if (Overflow && (FUNCT == FN_ADD || FUNCT == FN_SUB)) begin
                    next_state = EXC1;
                    next_vec   = VEC_OVERFLOW;
                end else begin
                    next_state = R_WB;
                end
            end
            ADDI_EXEC: begin
                if (Overflow) begin
                    next_state = EXC1;
                    next_vec   = VEC_OVERFLOW;
                end else begin
                    next_state = ADDI_WB;
                end
            end
            SH_LOAD:  next_state = SH_OP;
            SH_OP:    next_state = SH_WB;
            MEM_ADDR: next_state = (OPCODE == OP_LW) ? LW_READ : SW_WRITE;
            LW_READ:  next_state = LW_WAIT;
            LW_WAIT:  next_state = LW_LOAD;
            LW_LOAD:  next_state = LW_WB;
            EXC1:     next_state = EXC2;
            EXC2:     next_state = EXC3;
            EXC3:     next_state = EXC4;
            EXC4:     next_state = EXC5;
            default:  next_state = FETCH1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= FETCH1;
            exc_vec <= 2'd0;
            ctrl_q  <= '0;
        end else begin
            state   <= next_state;
            exc_vec <= next_vec;
            ctrl_q  <= decode_ctrl(next_state, FUNCT, next_vec);
        end
    end

    // Outputs are forced quiet for the whole time reset is held low, not just after the edge
    assign ctrl        = reset ? ctrl_q : '0;
    assign branch_take = (state == BRANCH) && ((OPCODE == OP_BEQ) ? Zero : !Zero);

    assign PCwrite      = ctrl.pc_write | (reset & branch_take);
    assign MemWrite     = ctrl.mem_write;
    assign MemRead      = ctrl.mem_read;
    assign IRWrite      = ctrl.ir_write;
    assign RegWrite     = ctrl.reg_write;
    assign EPCWrite     = ctrl.epc_write;
    assign MemToReg     = 1'b0;
    assign RegDest      = ctrl.reg_dest;
    assign IorD         = ctrl.iord;
    assign ExcpSel      = ctrl.excp_sel;
    assign AluSrcA      = ctrl.alu_src_a;
    assign AluSrcB      = ctrl.alu_src_b;
    assign ALUControl   = ctrl.alu_control;
    assign ShiftControl = ctrl.shift_control;
    assign PCSource     = ctrl.pc_source;
    assign WriteSrc     = ctrl.write_src;
    assign state_out    = reset ? state : FETCH1;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: per-instruction expected strobe/select timelines built from the
// instruction's class and cycle count, compared cycle by cycle against the FSM outputs.
module tb_control_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] OPCODE = 6'd0;
    logic [5:0] FUNCT = 6'd0;
    logic       Overflow = 1'b0;
    logic       Zero = 1'b0;
    logic       PCwrite, MemWrite, MemRead, IRWrite, RegWrite, EPCWrite, MemToReg;
    logic       RegDest, IorD, AluSrcA;
    logic [1:0] ExcpSel, AluSrcB, PCSource, WriteSrc;
    logic [2:0] ALUControl, ShiftControl;
    logic [5:0] state_out;

    int n_checks = 0;
    int n_fail = 0;

    localparam logic [5:0] FETCH1_CODE = 6'd0;
    localparam logic [6:0] S_PCW = 7'b1000000;
    localparam logic [6:0] S_MW  = 7'b0100000;
    localparam logic [6:0] S_MR  = 7'b0010000;
    localparam logic [6:0] S_IRW = 7'b0001000;
    localparam logic [6:0] S_RW  = 7'b0000100;
    localparam logic [6:0] S_EPC = 7'b0000010;

    typedef enum int {K_RALU, K_SHIFT, K_JR, K_ADDI, K_LW, K_SW, K_BR, K_J, K_ILL} kind_t;

    always #5 clk = ~clk;

    control_unit dut (
        .clk(clk), .reset(reset), .OPCODE(OPCODE), .FUNCT(FUNCT),
        .Overflow(Overflow), .Zero(Zero),
        .PCwrite(PCwrite), .MemWrite(MemWrite), .MemRead(MemRead), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .EPCWrite(EPCWrite), .MemToReg(MemToReg), .RegDest(RegDest),
        .IorD(IorD), .ExcpSel(ExcpSel), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB),
        .ALUControl(ALUControl), .ShiftControl(ShiftControl), .PCSource(PCSource),
        .WriteSrc(WriteSrc), .state_out(state_out)
    );

    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: begin
                if (fn == 6'h20 || fn == 6'h22 || fn == 6'h24) return K_RALU;
                if (fn == 6'h00 || fn == 6'h02) return K_SHIFT;
                if (fn == 6'h08) return K_JR;
                return K_ILL;
            end
            6'h08: return K_ADDI;
            6'h23: return K_LW;
            6'h2b: return K_SW;
            6'h04, 6'h05: return K_BR;
            6'h02: return K_J;
            default: return K_ILL;
        endcase
    endfunction

    // Runs one instruction from its FETCH1 cycle; abort_at>0 pulls reset low in that cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic ovf,
                             input logic zro, input int abort_at, input string tag);
        logic [6:0] es [1:16];
        int e_pcsrc [1:16];
        int e_wsrc [1:16];
        int e_rdst [1:16];
        int e_xsel [1:16];
        int e_iord [1:16];
        int e_alu [1:16];
        int e_shf [1:16];
        int e_srca [1:16];
        int e_srcb [1:16];
        logic [6:0] got;
        kind_t k;
        int n;
        int d;
        for (int c = 1; c <= 16; c++) begin
            es[c] = '0; e_pcsrc[c] = -1; e_wsrc[c] = -1; e_rdst[c] = -1; e_xsel[c] = -1;
            e_iord[c] = -1; e_alu[c] = -1; e_shf[c] = -1; e_srca[c] = -1; e_srcb[c] = -1;
        end
        k = classify(op, fn);
        n = 5;
        d = 0;
        for (int c = 2; c <= 3; c++) begin e_alu[c] = 1; e_srca[c] = 0; e_srcb[c] = 1; end
        es[3] = S_PCW | S_IRW; e_pcsrc[3] = 0;
        e_alu[4] = 1; e_srca[4] = 0; e_srcb[4] = 3;
        case (k)
            K_RALU: begin
                e_alu[5] = (fn == 6'h20) ? 1 : (fn == 6'h22) ? 2 : 3;
                e_srca[5] = 1; e_srcb[5] = 0;
                if (ovf && fn != 6'h24) d = 5;
                else begin
                    n = 6; es[6] = S_RW; e_rdst[6] = 1; e_wsrc[6] = 0;
                    e_alu[6] = e_alu[5]; e_srca[6] = 1; e_srcb[6] = 0;
                end
            end
            K_ADDI: begin
                e_alu[5] = 1; e_srca[5] = 1; e_srcb[5] = 2;
                if (ovf) d = 5;
                else begin n = 6; es[6] = S_RW; e_rdst[6] = 0; e_wsrc[6] = 0; end
            end
            K_SHIFT: begin
                n = 7; e_shf[5] = 1; e_shf[6] = (fn == 6'h00) ? 2 : 3;
                es[7] = S_RW; e_rdst[7] = 1; e_wsrc[7] = 2;
            end
            K_JR: begin es[5] = S_PCW; e_pcsrc[5] = 0; e_alu[5] = 0; e_srca[5] = 1; end
            K_J:  begin es[5] = S_PCW; e_pcsrc[5] = 2; end
            K_BR: begin
                es[5] = (((op == 6'h04) ? zro : !zro) == 1'b1) ? S_PCW : 7'd0;
                e_pcsrc[5] = 1; e_alu[5] = 2; e_srca[5] = 1; e_srcb[5] = 0;
            end
            K_LW: begin
                n = 9; e_alu[5] = 1; e_srca[5] = 1; e_srcb[5] = 2;
                for (int c = 6; c <= 8; c++) begin e_iord[c] = 1; e_xsel[c] = 0; end
                es[8] = S_MR; es[9] = S_RW; e_wsrc[9] = 1; e_rdst[9] = 0;
            end
            K_SW: begin
                n = 6; e_alu[5] = 1; e_srca[5] = 1; e_srcb[5] = 2;
                es[6] = S_MW; e_iord[6] = 1; e_xsel[6] = 0;
            end
            default: d = 4;
        endcase
        if (d != 0) begin
            n = d + 5;
            e_alu[d+1] = 2; e_srca[d+1] = 0; e_srcb[d+1] = 1;
            for (int c = d + 2; c <= d + 4; c++) begin
                e_iord[c] = 1; e_xsel[c] = (k == K_ILL) ? 1 : 2;
            end
            es[d+2] = S_EPC; es[d+4] = S_MR; es[d+5] = S_PCW; e_pcsrc[d+5] = 3;
        end
        for (int c = 1; c <= n; c++) begin
            if (c <= 3) begin
                OPCODE = 6'($urandom_range(0, 63)); FUNCT = 6'($urandom_range(0, 63));
            end else begin
                OPCODE = op; FUNCT = fn;
            end
            Overflow = 1'($urandom_range(0, 1));
            Zero = 1'($urandom_range(0, 1));
            if (c == 5 && (k == K_RALU || k == K_ADDI)) Overflow = ovf;
            if (c == 5 && k == K_BR) Zero = zro;
            if (c == abort_at) begin
                reset = 1'b0;
                #1;
                n_checks++;
                if ({PCwrite, MemWrite, MemRead, IRWrite, RegWrite, EPCWrite, MemToReg, RegDest,
                     IorD, ExcpSel, AluSrcA, AluSrcB, ALUControl, ShiftControl, PCSource,
                     WriteSrc} !== 24'd0 || state_out !== FETCH1_CODE) begin
                    n_fail++;
                    $display("FAIL %s abort cyc%0d outputs not quiet: state %0d RegWrite %b MemRead %b, required state %0d all 0",
                             tag, c, state_out, RegWrite, MemRead, FETCH1_CODE);
                end
                @(negedge clk);
                n_checks++;
                if (state_out !== FETCH1_CODE || RegWrite !== 1'b0 || MemRead !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s after abort edge: state %0d RegWrite %b MemRead %b, required %0d 0 0",
                             tag, state_out, RegWrite, MemRead, FETCH1_CODE);
                end
                reset = 1'b1;
                return;
            end
            #1;
            got = {PCwrite, MemWrite, MemRead, IRWrite, RegWrite, EPCWrite, MemToReg};
            n_checks++;
            if (got !== es[c]) begin
                n_fail++;
                $display("FAIL %s cyc%0d strobes {pcw,mw,mr,irw,rw,epc,m2r} got %b required %b",
                         tag, c, got, es[c]);
            end
            if (e_pcsrc[c] >= 0) begin
                n_checks++;
                if (PCSource !== 2'(e_pcsrc[c])) begin
                    n_fail++;
                    $display("FAIL %s cyc%0d PCSource got %0d required %0d", tag, c, PCSource, e_pcsrc[c]);
                end
            end
            if (e_wsrc[c] >= 0) begin
                n_checks++;
                if (WriteSrc !== 2'(e_wsrc[c])) begin
                    n_fail++;
                    $display("FAIL %s cyc%0d WriteSrc got %0d required %0d", tag, c, WriteSrc, e_wsrc[c]);
                end
            end
            if (e_rdst[c] >= 0) begin
                n_checks++;
                if (RegDest !== 1'(e_rdst[c])) begin
                    n_fail++;
                    $display("FAIL %s cyc%0d RegDest got %0d required %0d", tag, c, RegDest, e_rdst[c]);
                end
            end
            if (e_xsel[c] >= 0) begin
                n_checks++;
                if (ExcpSel !== 2'(e_xsel[c]) || IorD !== 1'(e_iord[c])) begin
                    n_fail++;
                    $display("FAIL %s cyc%0d ExcpSel/IorD got %0d/%0d required %0d/%0d",
                             tag, c, ExcpSel, IorD, e_xsel[c], e_iord[c]);
                end
            end
            if (e_alu[c] >= 0) begin
                n_checks++;
                if (ALUControl !== 3'(e_alu[c])) begin
                    n_fail++;
                    $display("FAIL %s cyc%0d ALUControl got %0d required %0d", tag, c, ALUControl, e_alu[c]);
                end
            end
            if (e_srca[c] >= 0 && e_srcb[c] >= 0) begin
                n_checks++;
                if (AluSrcA !== 1'(e_srca[c]) || AluSrcB !== 2'(e_srcb[c])) begin
                    n_fail++;
                    $display("FAIL %s cyc%0d AluSrcA/B got %0d/%0d required %0d/%0d",
                             tag, c, AluSrcA, AluSrcB, e_srca[c], e_srcb[c]);
                end
            end
            if (e_shf[c] >= 0) begin
                n_checks++;
                if (ShiftControl !== 3'(e_shf[c])) begin
                    n_fail++;
                    $display("FAIL %s cyc%0d ShiftControl got %0d required %0d", tag, c, ShiftControl, e_shf[c]);
                end
            end
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (state_out !== FETCH1_CODE) begin
            n_fail++;
            $display("FAIL %s end state got %0d required %0d after %0d cycles", tag, state_out, FETCH1_CODE, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (state_out !== FETCH1_CODE) begin
            n_fail++;
            $display("FAIL reset state got %0d required %0d", state_out, FETCH1_CODE);
        end
        n_checks++;
        if ({PCwrite, MemWrite, MemRead, IRWrite, RegWrite, EPCWrite, MemToReg, RegDest, IorD,
             ExcpSel, AluSrcA, AluSrcB, ALUControl, ShiftControl, PCSource, WriteSrc} !== 24'd0) begin
            n_fail++;
            $display("FAIL reset outputs got PCwrite %b RegWrite %b AluSrcB %0d ALUControl %0d, required all 0",
                     PCwrite, RegWrite, AluSrcB, ALUControl);
        end
        reset = 1'b1;
        run_instr(6'h00, 6'h20, 1'b0, 1'b0, 0, "first_add");
    endtask

    task automatic test_r_type();
        run_instr(6'h00, 6'h22, 1'b0, 1'b1, 0, "sub");
        run_instr(6'h00, 6'h24, 1'b1, 1'b0, 0, "and_ovf_ignored");
        run_instr(6'h08, 6'h11, 1'b0, 1'b0, 0, "addi");
        run_instr(6'h00, 6'h00, 1'b1, 1'b0, 0, "sll");
        run_instr(6'h00, 6'h02, 1'b0, 1'b1, 0, "srl");
        run_instr(6'h00, 6'h08, 1'b0, 1'b0, 0, "jr");
    endtask

    task automatic test_mem();
        run_instr(6'h23, 6'h04, 1'b1, 1'b0, 0, "lw");
        run_instr(6'h2b, 6'h08, 1'b1, 1'b1, 0, "sw");
    endtask

    task automatic test_branch();
        run_instr(6'h04, 6'h00, 1'b0, 1'b1, 0, "beq_taken");
        run_instr(6'h04, 6'h00, 1'b0, 1'b0, 0, "beq_not_taken");
        run_instr(6'h05, 6'h00, 1'b0, 1'b1, 0, "bne_zero1");
        run_instr(6'h05, 6'h00, 1'b0, 1'b0, 0, "bne_taken");
        run_instr(6'h02, 6'h3c, 1'b0, 1'b0, 0, "j");
    endtask

    task automatic test_exceptions();
        run_instr(6'h00, 6'h20, 1'b1, 1'b0, 0, "add_ovf");
        run_instr(6'h00, 6'h22, 1'b1, 1'b0, 0, "sub_ovf");
        run_instr(6'h08, 6'h00, 1'b1, 1'b0, 0, "addi_ovf");
        run_instr(6'h3f, 6'h20, 1'b0, 1'b0, 0, "op_3f");
        run_instr(6'h00, 6'h21, 1'b0, 1'b0, 0, "bad_funct");
    endtask

    task automatic test_reset_mid_instr();
        run_instr(6'h23, 6'h00, 1'b0, 1'b0, 7, "lw_abort_wait");
        run_instr(6'h00, 6'h20, 1'b0, 1'b0, 0, "add_after_abort");
        run_instr(6'h05, 6'h00, 1'b0, 1'b0, 5, "bne_abort");
        run_instr(6'h2b, 6'h00, 1'b0, 1'b0, 0, "sw_after_abort");
    endtask

    task automatic test_random();
        logic [5:0] ops [8] = '{6'h00, 6'h00, 6'h08, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02};
        logic [5:0] fns [6] = '{6'h20, 6'h22, 6'h24, 6'h00, 6'h02, 6'h08};
        logic [5:0] op;
        logic [5:0] fn;
        for (int i = 0; i < 60; i++) begin
            op = (($urandom_range(0, 7)) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 7)];
            fn = (($urandom_range(0, 7)) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 5)];
            run_instr(op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_mem();
        test_branch();
        test_exceptions();
        test_reset_mid_instr();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0d comparisons", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
